// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift serializer controller: state encoding
// and serial direction constants.
package shift_ctrl_pkg;

    // Controller state encoding (2 bits).
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOADED = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Serial bit order selected per word.
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_LOADED = LOADED,
        ST_SHIFT  = SHIFT,
        ST_DONE   = DONE
    } state_e;

endpackage

// File: rtl/shift_dir_reg.sv
// Loadable WIDTH-bit shift register; shifts left or right by one with a
// zero fill. Load has priority over shift so the controller can also use
// it to clear the register.
module shift_dir_reg
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] reg_q;

    // Register update: load, else shift toward the emitted end, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_q <= '0;
        end else if (load) begin
            reg_q <= d;
        end else if (shift_en) begin
            if (dir == DIR_MSB_FIRST) begin
                reg_q <= {reg_q[WIDTH-2:0], 1'b0};
            end else begin
                reg_q <= {1'b0, reg_q[WIDTH-1:1]};
            end
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/shift_serializer_ctrl.sv
// Parallel-to-serial controller: accepts one word per valid/ready handshake,
// spends one cycle loading it, then emits one bit per accepted serial beat
// in the per-word selected order, and pulses done after the last bit.
module shift_serializer_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] shreg_q;
    logic             is_last;

    assign is_last = (count_q == LAST_CNT);

    shift_dir_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .shift_en (shift_en),
        .dir      (dir_q),
        .d        (load_data),
        .q        (shreg_q)
    );

    // State, bit counter and latched direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state, register control and handshake outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dir_d     = dir_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        load_data = in_data;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort is meaningless here, so a coincident word is still taken
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    dir_d   = in_msb_first;
                    count_d = '0;
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                busy = 1'b1;
                if (abort) begin
                    load      = 1'b1;
                    load_data = '0;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = (dir_q == DIR_MSB_FIRST) ? shreg_q[WIDTH-1] : shreg_q[0];
                ser_last  = is_last;
                if (abort) begin
                    // abort beats a final accepted beat: no done pulse
                    load      = 1'b1;
                    load_data = '0;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else if (ser_ready) begin
                    shift_en = 1'b1;
                    if (is_last) begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Self-checking bench for shift_serializer_ctrl: directed scenarios plus
// randomized words, stalls and aborts checked against a bit-order model.
module tb_shift_serializer_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_msb_first = 1'b0;
    logic         abort = 1'b0;
    logic         ser_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, ser_out, ser_valid, ser_last, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_serializer_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .abort        (abort),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .ser_last     (ser_last),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference bit order: the i-th emitted bit of a word.
    function automatic logic exp_bit(input logic [W-1:0] d, input logic msb, input int i);
        return msb ? d[W-1-i] : d[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Offer a word until taken; returns in the LOADED cycle just after the edge.
    task automatic handshake(input logic [W-1:0] d, input logic msb, input logic keep,
                             input logic [W-1:0] d2, input logic msb2,
                             input logic with_abort, output int acc_cyc);
        tick();
        in_valid = 1'b1;
        in_data = d;
        in_msb_first = msb;
        abort = with_abort;
        for (int t = 0; t < 60; t++) begin
            settle();
            if (in_ready === 1'b1) break;
            tick();
        end
        chk("handshake_ready", in_ready, 1);
        tick();
        acc_cyc = cyc;
        abort = 1'b0;
        if (keep) begin
            in_data = d2;
            in_msb_first = msb2;
        end else begin
            in_valid = 1'b0;
            in_data = W'($urandom);
        end
    endtask

    // Follow one accepted word through LOADED, its beats and DONE; ends at the
    // negedge of the IDLE cycle afterwards.
    task automatic follow(input logic [W-1:0] d, input logic msb, input logic noisy,
                          input int stall_at, input int stall_len, input int abort_at,
                          input logic keep_valid);
        int i = 0;
        int stalls = 0;
        int el = 0;
        int held = 0;
        logic rdy;
        logic ab;
        ser_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (noisy) in_valid = 1'($urandom_range(0, 1));
        settle();
        chk("loaded_ser_valid", ser_valid, 0);
        chk("loaded_busy", busy, 1);
        chk("loaded_in_ready", in_ready, 0);
        chk("loaded_done", done, 0);
        tick();
        el = 1;
        for (int g = 0; g < 400 && i < W; g++) begin
            if (noisy) rdy = ($urandom_range(0, 3) != 0);
            else if (i == stall_at && held < stall_len) rdy = 1'b0;
            else rdy = 1'b1;
            ab = (i == abort_at) && rdy;
            ser_ready = rdy;
            abort = ab;
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = W'($urandom);
            end
            settle();
            chk("beat_valid", ser_valid, 1);
            chk("beat_bit", ser_out, exp_bit(d, msb, i));
            chk("beat_last", ser_last, (i == W - 1) ? 1 : 0);
            chk("beat_busy", busy, 1);
            chk("beat_done", done, 0);
            tick();
            el++;
            abort = 1'b0;
            if (ab) begin
                in_valid = 1'b0;
                ser_ready = 1'b0;
                settle();
                chk("abort_in_ready", in_ready, 1);
                chk("abort_busy", busy, 0);
                chk("abort_no_done", done, 0);
                chk("abort_ser_valid", ser_valid, 0);
                return;
            end
            if (rdy) i++;
            else begin
                stalls++;
                held++;
            end
        end
        chk("bit_count", i, W);
        if (noisy) begin
            abort = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
        end
        settle();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_in_ready", in_ready, 0);
        chk("done_ser_valid", ser_valid, 0);
        chk("done_latency", el, W + 1 + stalls);
        tick();
        abort = 1'b0;
        if (!keep_valid) in_valid = 1'b0;
        settle();
        chk("idle_done_low", done, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int acc1, acc2;
        logic [W-1:0] rd;
        logic rm;
        int ra;

        // Reset held three cycles
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        settle();
        chk("rst_ser_out", ser_out, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_last", ser_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        tick();
        tick();
        settle();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        $display("reset: checks=%0d errors=%0d", checks, errors);

        // MSB-first 0xA8, no backpressure
        handshake(8'hA8, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc1);
        follow(8'hA8, 1'b1, 1'b0, -1, 0, -1, 1'b0);
        $display("word A8 msb-first: checks=%0d errors=%0d", checks, errors);

        // LSB-first 0xA8
        handshake(8'hA8, 1'b0, 1'b0, '0, 1'b0, 1'b0, acc1);
        follow(8'hA8, 1'b0, 1'b0, -1, 0, -1, 1'b0);
        $display("word A8 lsb-first: checks=%0d errors=%0d", checks, errors);

        // Backpressure: stall 3 cycles on bit 2
        handshake(8'hFF, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc1);
        follow(8'hFF, 1'b1, 1'b0, 2, 3, -1, 1'b0);
        $display("word FF stalled: checks=%0d errors=%0d", checks, errors);

        // Abort at bit 4, then a fresh word
        handshake(8'h0F, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc1);
        follow(8'h0F, 1'b1, 1'b0, -1, 0, 4, 1'b0);
        handshake(8'hF0, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc1);
        follow(8'hF0, 1'b1, 1'b0, -1, 0, -1, 1'b0);
        $display("word 0F aborted, F0 sent: checks=%0d errors=%0d", checks, errors);

        // Abort on the final accepted beat wins
        handshake(8'hC3, 1'b0, 1'b0, '0, 1'b0, 1'b0, acc1);
        follow(8'hC3, 1'b0, 1'b0, -1, 0, W - 1, 1'b0);
        $display("word C3 abort on last: checks=%0d errors=%0d", checks, errors);

        // abort together with in_valid in IDLE: word still accepted
        handshake(8'h5A, 1'b1, 1'b0, '0, 1'b0, 1'b1, acc1);
        follow(8'h5A, 1'b1, 1'b0, -1, 0, -1, 1'b0);
        $display("word 5A with idle abort: checks=%0d errors=%0d", checks, errors);

        // Back-to-back with in_valid held high
        handshake(8'h55, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, acc1);
        follow(8'h55, 1'b1, 1'b0, -1, 0, -1, 1'b1);
        tick();
        acc2 = cyc;
        in_valid = 1'b0;
        chk("b2b_spacing", acc2 - acc1, W + 3);
        follow(8'h33, 1'b0, 1'b0, -1, 0, -1, 1'b0);
        $display("words 55,33 back-to-back: checks=%0d errors=%0d", checks, errors);

        // Reset mid-word
        handshake(8'hA5, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc1);
        ser_ready = 1'b1;
        settle();
        tick();
        settle();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ser_valid", ser_valid, 0);
        chk("midrst_ser_out", ser_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        settle();
        tick();
        reset_n = 1'b1;
        settle();
        chk("midrst_no_done", done, 0);
        chk("midrst_idle", in_ready, 1);
        $display("reset mid-word: checks=%0d errors=%0d", checks, errors);

        // Randomized words, direction, stalls, noise and aborts
        for (int n = 0; n < 24; n++) begin
            rd = W'($urandom);
            rm = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            handshake(rd, rm, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), acc1);
            follow(rd, rm, 1'b1, -1, 0, ra, 1'b0);
            $display("random word %0d data=%0h msb=%0d abort_at=%0d: checks=%0d errors=%0d",
                     n, rd, rm, ra, checks, errors);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
